// File: rtl/seq_det_param.sv
// seq_det_param: parametrised Moore serial pattern detector with KMP fallback and saturating match count
module seq_det_param #(
  parameter int N = 3,
  parameter logic [N-1:0] PATTERN = 3'b101,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W = 8,
  localparam int PW = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             en,
  input  logic             pat_ld,
  input  logic [N-1:0]     pat_in,
  output logic             z,
  output logic [CNT_W-1:0] cnt,
  output logic [PW-1:0]    ps
);
  localparam logic [PW-1:0] FULL = PW'(N);
  logic [N-1:0] pat_reg;
  logic [PW-1:0] cur, nxt;
  logic ok;
  assign cur = (ps == FULL && !OVERLAP) ? '0 : ps;
  assign z = ps == FULL;
  always_comb begin
    nxt = '0;
    ok = 1'b0;
    for (int k = 0; k <= N; k++)
      for (int j = 1; j <= k + 1 && j <= N; j++) begin
        ok = PW'(k) == cur && x == pat_reg[N-j];
        for (int i = 0; i < j - 1; i++)
          ok = ok && pat_reg[N-2-k+j-i] == pat_reg[N-1-i];
        if (ok) nxt = PW'(j);
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      pat_reg <= PATTERN;
      ps <= '0;
      cnt <= '0;
    end else if (pat_ld) begin
      pat_reg <= pat_in;
      ps <= '0;
      cnt <= '0;
    end else if (en) begin
      ps <= nxt;
      if (nxt == FULL && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: random and directed streams into two detector builds, checked by a suffix-matching reference model
module tb_seq_det_param;
  logic clk = 1'b0;
  logic rst, x, en, pat_ld;
  logic [2:0] pin_a;
  logic [3:0] pin_b;
  logic z_a, z_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [1:0] ps_a;
  logic [2:0] ps_b;
  always #5 clk = ~clk;
  seq_det_param dut_a (.clk(clk), .rst(rst), .x(x), .en(en), .pat_ld(pat_ld), .pat_in(pin_a), .z(z_a), .cnt(cnt_a), .ps(ps_a));
  seq_det_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .x(x), .en(en), .pat_ld(pat_ld), .pat_in(pin_b), .z(z_b), .cnt(cnt_b), .ps(ps_b));
  typedef struct packed {int ps0; int ps1; int c0; int c1;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, passes = 0;
  int n[2] = '{3, 4};
  int ov[2] = '{1, 0};
  int cmax[2] = '{255, 3};
  int dflt[2] = '{5, 13};
  int pat[2], hlen[2], mps[2], mcnt[2];
  bit [7:0] hist[2];
  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask
  function automatic int longest(input int d);
    int top;
    bit good;
    top = hlen[d] < n[d] ? hlen[d] : n[d];
    for (int j = top; j >= 1; j--) begin
      good = 1'b1;
      for (int i = 0; i < j; i++)
        if (int'(hist[d][j-1-i]) != ((pat[d] >> (n[d] - 1 - i)) & 1)) good = 1'b0;
      if (good) return j;
    end
    return 0;
  endfunction
  task automatic model(input bit r, input bit l, input bit en_b, input bit xb, input int pa, input int pb);
    for (int d = 0; d < 2; d++)
      if (r) begin
        pat[d] = dflt[d]; hlen[d] = 0; mps[d] = 0; mcnt[d] = 0;
      end else if (l) begin
        pat[d] = d ? pb : pa; hlen[d] = 0; mps[d] = 0; mcnt[d] = 0;
      end else if (en_b) begin
        hist[d] = {hist[d][6:0], xb};
        hlen[d] = hlen[d] < 8 ? hlen[d] + 1 : 8;
        mps[d] = longest(d);
        if (mps[d] == n[d]) begin
          if (mcnt[d] < cmax[d]) mcnt[d]++;
          if (!ov[d]) hlen[d] = 0;
        end
      end
  endtask
  task automatic drive(input bit r, input bit l, input bit en_b, input bit xb, input logic [2:0] pa, input logic [3:0] pb);
    rst = r; pat_ld = l; en = en_b; x = xb; pin_a = pa; pin_b = pb;
    model(r, l, en_b, xb, int'(pa), int'(pb));
    @(posedge clk);
    q.push_back('{mps[0], mps[1], mcnt[0], mcnt[1]});
    #1;
  endtask
  task automatic bits(input logic [31:0] v, input int len);
    for (int i = len - 1; i >= 0; i--) drive(1'b0, 1'b0, 1'b1, v[i], 3'd0, 4'd0);
  endtask
  initial forever begin
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("ps_a", int'(ps_a), e.ps0);
      chk("z_a", int'(z_a), int'(e.ps0 == 3));
      chk("cnt_a", int'(cnt_a), e.c0);
      chk("ps_b", int'(ps_b), e.ps1);
      chk("z_b", int'(z_b), int'(e.ps1 == 4));
      chk("cnt_b", int'(cnt_b), e.c1);
    end
  end
  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    bits(32'b10101, 5);
    bits(32'b10, 2);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, i[0], 3'd0, 4'd0);
    bits(32'b1, 1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, ~i[0], 3'd0, 4'd0);
    bits(32'b11101101, 8);
    bits(32'b10, 2);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b011, 4'b1111);
    bits(32'b011, 3);
    bits(32'b01, 2);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 4'd0);
    bits(32'b101, 3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 4'b1111);
    bits(32'hfffff, 20);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    bits(32'b0, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            1'($urandom), 3'($urandom), 4'($urandom));
    #5;
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
